// File: rtl/dm_responder.sv
// Data-memory responder for the MEM-stage data port: combinational extended loads,
// edge-triggered byte/half/word stores, per-word valid bitmap and sticky store-error capture.
module dm_responder #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_w,
  input  logic [31:0]   Addr_in,
  input  logic [31:0]   Data_in,
  input  logic [2:0]    dm_ctrl,
  output logic [31:0]   Data_out,
  input  logic          err_clr,
  output logic          err_valid,
  output logic [1:0]    err_code,
  output logic [31:0]   err_addr,
  input  logic [AW-1:0] dbg_idx,
  output logic [31:0]   dbg_data
);

  localparam logic [2:0] CtrlWord  = 3'b000;
  localparam logic [2:0] CtrlHalf  = 3'b001;
  localparam logic [2:0] CtrlHalfU = 3'b010;
  localparam logic [2:0] CtrlByte  = 3'b011;
  localparam logic [2:0] CtrlByteU = 3'b100;

  localparam logic [1:0] ErrMisaligned = 2'b01;
  localparam logic [1:0] ErrRange      = 2'b10;
  localparam logic [1:0] ErrReserved   = 2'b11;

  logic [31:0]    r_mem [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic           r_errValid;
  logic [1:0]     r_errCode;
  logic [31:0]    r_errAddr;

  logic [29:0]    w_wordAddr;
  logic [AW-1:0]  w_idx;
  logic [1:0]     w_off;
  logic           w_isWord;
  logic           w_isHalf;
  logic           w_isByte;
  logic           w_reserved;
  logic           w_inRange;
  logic           w_misaligned;
  logic           w_illegal;
  logic [1:0]     w_errCode;
  logic [31:0]    w_base;
  logic [15:0]    w_halfLane;
  logic [7:0]     w_byteLane;
  logic [31:0]    w_merged;
  logic           w_storeEn;
  logic           w_errCapture;

  assign w_wordAddr = Addr_in[31:2];
  assign w_idx      = Addr_in[AW+1:2];
  assign w_off      = Addr_in[1:0];

  assign w_isWord   = (dm_ctrl == CtrlWord);
  assign w_isHalf   = (dm_ctrl == CtrlHalf) || (dm_ctrl == CtrlHalfU);
  assign w_isByte   = (dm_ctrl == CtrlByte) || (dm_ctrl == CtrlByteU);
  assign w_reserved = !(w_isWord || w_isHalf || w_isByte);

  assign w_inRange    = ({2'b00, w_wordAddr} < 32'(DEPTH));
  assign w_misaligned = (w_isWord && (w_off != 2'b00)) || (w_isHalf && w_off[0]);
  assign w_illegal    = w_reserved || !w_inRange || w_misaligned;

  // Classification priority: reserved ctrl, then range, then alignment.
  always_comb begin
    w_errCode = 2'b00;
    if (w_reserved)
      w_errCode = ErrReserved;
    else if (!w_inRange)
      w_errCode = ErrRange;
    else if (w_misaligned)
      w_errCode = ErrMisaligned;
  end

  // Unwritten words read as zero, both for loads and as the merge base for partial stores.
  assign w_base   = r_valid[w_idx] ? r_mem[w_idx] : 32'h0;
  assign dbg_data = r_valid[dbg_idx] ? r_mem[dbg_idx] : 32'h0;

  assign w_halfLane = w_off[1] ? w_base[31:16] : w_base[15:0];

  always_comb begin
    w_byteLane = w_base[7:0];
    case (w_off)
      2'd0: w_byteLane = w_base[7:0];
      2'd1: w_byteLane = w_base[15:8];
      2'd2: w_byteLane = w_base[23:16];
      2'd3: w_byteLane = w_base[31:24];
      default: w_byteLane = w_base[7:0];
    endcase
  end

  always_comb begin
    Data_out = 32'h0;
    if (!w_illegal) begin
      case (dm_ctrl)
        CtrlWord:  Data_out = w_base;
        CtrlHalf:  Data_out = {{16{w_halfLane[15]}}, w_halfLane};
        CtrlHalfU: Data_out = {16'h0, w_halfLane};
        CtrlByte:  Data_out = {{24{w_byteLane[7]}}, w_byteLane};
        CtrlByteU: Data_out = {24'h0, w_byteLane};
        default:   Data_out = 32'h0;
      endcase
    end
  end

  always_comb begin
    w_merged = w_base;
    if (w_isWord) begin
      w_merged = Data_in;
    end else if (w_isHalf) begin
      if (w_off[1])
        w_merged[31:16] = Data_in[15:0];
      else
        w_merged[15:0] = Data_in[15:0];
    end else if (w_isByte) begin
      case (w_off)
        2'd0: w_merged[7:0]   = Data_in[7:0];
        2'd1: w_merged[15:8]  = Data_in[7:0];
        2'd2: w_merged[23:16] = Data_in[7:0];
        2'd3: w_merged[31:24] = Data_in[7:0];
        default: w_merged = w_base;
      endcase
    end
  end

  assign w_storeEn    = mem_w && !w_illegal && !rst;
  assign w_errCapture = mem_w && w_illegal && (err_clr || !r_errValid);

  // The array itself has no reset; the valid bitmap alone decides what reads back.
  always_ff @(posedge clk) begin
    if (w_storeEn)
      r_mem[w_idx] <= w_merged;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_valid <= '0;
    else if (w_storeEn)
      r_valid[w_idx] <= 1'b1;
  end

  // Clear happens first, so a same-edge illegal store is still recorded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_errValid <= 1'b0;
      r_errCode  <= 2'b00;
      r_errAddr  <= 32'h0;
    end else begin
      if (err_clr) begin
        r_errValid <= 1'b0;
        r_errCode  <= 2'b00;
        r_errAddr  <= 32'h0;
      end
      if (w_errCapture) begin
        r_errValid <= 1'b1;
        r_errCode  <= w_errCode;
        r_errAddr  <= Addr_in;
      end
    end
  end

  assign err_valid = r_errValid;
  assign err_code  = r_errCode;
  assign err_addr  = r_errAddr;

endmodule

// File: tb/tb_dm_responder.sv
// Directed self-checking bench for dm_responder: loads, stores, error capture and reset.
module tb_dm_responder;

  logic        clk;
  logic        rst;
  logic        mem_w;
  logic [31:0] Addr_in;
  logic [31:0] Data_in;
  logic [2:0]  dm_ctrl;
  logic [31:0] Data_out;
  logic        err_clr;
  logic        err_valid;
  logic [1:0]  err_code;
  logic [31:0] err_addr;
  logic [9:0]  dbg_idx;
  logic [31:0] dbg_data;

  int testCount = 0;
  int failCount = 0;

  dm_responder #(.DEPTH(1024), .AW(10)) dut (
    .clk      (clk),
    .rst      (rst),
    .mem_w    (mem_w),
    .Addr_in  (Addr_in),
    .Data_in  (Data_in),
    .dm_ctrl  (dm_ctrl),
    .Data_out (Data_out),
    .err_clr  (err_clr),
    .err_valid(err_valid),
    .err_code (err_code),
    .err_addr (err_addr),
    .dbg_idx  (dbg_idx),
    .dbg_data (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Drives one store cycle from the falling edge and returns just after the rising edge.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                               input logic [2:0] ctrl, input logic clr);
    @(negedge clk);
    mem_w   = 1'b1;
    Addr_in = addr;
    Data_in = data;
    dm_ctrl = ctrl;
    err_clr = clr;
    @(posedge clk);
    #1;
    mem_w   = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic loadCheck(input string tag, input logic [31:0] addr, input logic [2:0] ctrl,
                           input logic [31:0] expected);
    Addr_in = addr;
    dm_ctrl = ctrl;
    #1;
    checkOutput(tag, Data_out, expected);
  endtask

  task automatic dbgCheck(input string tag, input logic [9:0] idx, input logic [31:0] expected);
    dbg_idx = idx;
    #1;
    checkOutput(tag, dbg_data, expected);
  endtask

  task automatic errCheck(input string tag, input logic v, input logic [1:0] code, input logic [31:0] addr);
    checkOutput({tag, "_valid"}, {31'h0, err_valid}, {31'h0, v});
    checkOutput({tag, "_code"},  {30'h0, err_code},  {30'h0, code});
    checkOutput({tag, "_addr"},  err_addr, addr);
  endtask

  initial begin
    rst     = 1'b1;
    mem_w   = 1'b0;
    Addr_in = 32'h0;
    Data_in = 32'h0;
    dm_ctrl = 3'b000;
    err_clr = 1'b0;
    dbg_idx = 10'd0;
    #23;
    errCheck("reset_err", 1'b0, 2'b00, 32'h0);
    rst = 1'b0;
    #2;

    loadCheck("reset_load_0x10", 32'h10, 3'b000, 32'h0);
    dbgCheck("reset_dbg_4", 10'd4, 32'h0);

    applyStimulus(32'h8, 32'h12345678, 3'b000, 1'b0);
    loadCheck("byteu_0x9", 32'h9, 3'b100, 32'h00000056);
    loadCheck("byte_0x9",  32'h9, 3'b011, 32'h00000056);
    loadCheck("half_0xA",  32'hA, 3'b001, 32'h00001234);
    loadCheck("halfu_0x8", 32'h8, 3'b010, 32'h00005678);
    loadCheck("word_0x8",  32'h8, 3'b000, 32'h12345678);
    dbgCheck("dbg_2", 10'd2, 32'h12345678);
    errCheck("legal_no_err", 1'b0, 2'b00, 32'h0);

    applyStimulus(32'h3, 32'hFFFFFF80, 3'b011, 1'b0);
    dbgCheck("dbg_0_byte", 10'd0, 32'h80000000);
    loadCheck("byte_0x3",  32'h3, 3'b011, 32'hFFFFFF80);
    loadCheck("byteu_0x3", 32'h3, 3'b100, 32'h00000080);
    loadCheck("half_0x2",  32'h2, 3'b001, 32'hFFFF8000);
    loadCheck("halfu_0x2", 32'h2, 3'b010, 32'h00008000);

    applyStimulus(32'h2, 32'h0000BEEF, 3'b010, 1'b0);
    dbgCheck("dbg_0_half", 10'd0, 32'hBEEF0000);

    loadCheck("misaligned_load", 32'h6, 3'b000, 32'h0);
    loadCheck("misaligned_half_load", 32'h9, 3'b001, 32'h0);
    loadCheck("reserved_load", 32'h8, 3'b110, 32'h0);
    errCheck("loads_no_err", 1'b0, 2'b00, 32'h0);
    applyStimulus(32'h6, 32'hDEADBEEF, 3'b000, 1'b0);
    errCheck("misaligned_err", 1'b1, 2'b01, 32'h6);
    dbgCheck("dbg_1_unwritten", 10'd1, 32'h0);
    applyStimulus(32'hFFFF0000, 32'h11111111, 3'b000, 1'b0);
    errCheck("sticky_err", 1'b1, 2'b01, 32'h6);
    dbgCheck("dbg_0_range_alias", 10'd0, 32'hBEEF0000);

    applyStimulus(32'h20, 32'h22222222, 3'b101, 1'b1);
    errCheck("clr_and_reserved", 1'b1, 2'b11, 32'h20);
    dbgCheck("dbg_8_unwritten", 10'd8, 32'h0);

    @(negedge clk);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    errCheck("clr_only", 1'b0, 2'b00, 32'h0);

    applyStimulus(32'h1000, 32'h33333333, 3'b000, 1'b0);
    errCheck("range_err", 1'b1, 2'b10, 32'h1000);
    loadCheck("range_load", 32'h1000, 3'b000, 32'h0);
    applyStimulus(32'hFFC, 32'h44444444, 3'b000, 1'b0);
    dbgCheck("dbg_1023", 10'd1023, 32'h44444444);
    loadCheck("last_word_load", 32'hFFC, 3'b000, 32'h44444444);

    applyStimulus(32'h40, 32'hA5A5A5A5, 3'b000, 1'b0);
    @(negedge clk);
    mem_w   = 1'b1;
    Addr_in = 32'h40;
    Data_in = 32'h5A5A5A5A;
    dm_ctrl = 3'b000;
    #1;
    checkOutput("same_cycle_old", Data_out, 32'hA5A5A5A5);
    @(posedge clk);
    #1;
    mem_w = 1'b0;
    checkOutput("next_cycle_new", Data_out, 32'h5A5A5A5A);

    @(negedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    loadCheck("post_reset_0x40", 32'h40, 3'b000, 32'h0);
    errCheck("post_reset_err", 1'b0, 2'b00, 32'h0);
    dbgCheck("post_reset_dbg_2", 10'd2, 32'h0);

    @(negedge clk);
    mem_w   = 1'b1;
    Addr_in = 32'h44;
    Data_in = 32'h77777777;
    dm_ctrl = 3'b000;
    rst     = 1'b1;
    @(posedge clk);
    #1;
    mem_w = 1'b0;
    rst   = 1'b0;
    dbgCheck("store_during_reset", 10'd17, 32'h0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
